pipe_ctrl_unit: RTL and testbench

- Parametrised pipeline hazard controller; successor to the fixed 4-boundary stall/flush combiner.
- Sits between all stage hazard requesters and every pipeline register (PC, IF/ID, ID/EX, EX/MA, ...).
- Adds N-stage generalisation, multi-cycle flush stretching, flush-over-stall priority and a stall watchdog.

---
 rtl/pipe_ctrl_unit_pkg.sv | 18 +
 rtl/flush_stretch.sv | 34 +++
 rtl/pipe_ctrl_unit.sv | 127 ++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared pipeline control types and constants: boundary indices, per-boundary
// control pair and default tuning values for pipe_ctrl_unit.
package pipe_ctrl_unit_pkg;

  localparam int PIPE_PC    = 0;
  localparam int PIPE_IF_ID = 1;
  localparam int PIPE_ID_EX = 2;
  localparam int PIPE_EX_MA = 3;

  localparam int PIPE_WD_LIMIT_DEF   = 64;
  localparam int PIPE_FLUSH_HOLD_DEF = 1;

  typedef struct packed {
    logic stall;
    logic flush;
  } pipe_ctrl_t;

endpackage

// File: rtl/flush_stretch.sv
// One boundary's flush stretcher: flush is raw request OR a registered tail
// that keeps it asserted for FLUSH_HOLD cycles in total.
module flush_stretch
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int FLUSH_HOLD = PIPE_FLUSH_HOLD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_flush,
  output logic flush
);

  localparam int HW = $clog2(FLUSH_HOLD + 1);

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  // A fresh request always reloads, so back-to-back requests only extend.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (raw_flush)
      hold_cnt_d = HW'(FLUSH_HOLD - 1);
    else if (hold_cnt_q != '0)
      hold_cnt_d = hold_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt_q <= '0;
    else        hold_cnt_q <= hold_cnt_d;
  end

  assign flush = raw_flush | (hold_cnt_q != '0);

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Parametrised pipeline stall/flush controller with flush stretch, flush-over-stall
// masking and a stall watchdog. Optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int NSTAGE           = 4,
  parameter int FLUSH_HOLD       = PIPE_FLUSH_HOLD_DEF,
  parameter int FLUSH_OVER_STALL = 1,
  parameter int WD_LIMIT         = PIPE_WD_LIMIT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NSTAGE-1:0]        stall_req,
  input  logic [NSTAGE*NSTAGE-1:0] flush_req,
  input  logic                     wd_clr,
  output logic [NSTAGE-1:0]        stall,
  output logic [NSTAGE-1:0]        flush,
  output logic                     wd_trip,
  output logic                     wd_err,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_flush_cnt
);

  logic [NSTAGE-1:0] raw_stall, raw_flush, flush_w;
  pipe_ctrl_t        ctrl [NSTAGE];

  // A requester stalls its own boundary and everything upstream of it.
  always_comb begin
    raw_stall = '0;
    raw_flush = '0;
    for (int b = 0; b < NSTAGE; b++) begin
      for (int r = 0; r < NSTAGE; r++) begin
        if (r >= b) raw_stall[b] = raw_stall[b] | stall_req[r];
        raw_flush[b] = raw_flush[b] | flush_req[r*NSTAGE + b];
      end
    end
  end

  for (genvar b = 0; b < NSTAGE; b++) begin : g_bnd
    flush_stretch #(.FLUSH_HOLD(FLUSH_HOLD)) u_fs (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_flush (raw_flush[b]),
      .flush     (flush_w[b])
    );
  end

  always_comb begin
    for (int b = 0; b < NSTAGE; b++) begin
      ctrl[b].flush = flush_w[b];
      ctrl[b].stall = (FLUSH_OVER_STALL != 0) ? (raw_stall[b] & ~flush_w[b])
                                              : raw_stall[b];
      stall[b] = ctrl[b].stall;
      flush[b] = ctrl[b].flush;
    end
  end

  if (WD_LIMIT > 0) begin : g_wd
    localparam int WW = (WD_LIMIT > 1) ? $clog2(WD_LIMIT) : 1;

    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    logic          wd_err_q, wd_err_d;
    logic          trip;

    assign trip = stall[PIPE_PC] & (wd_cnt_q == WW'(WD_LIMIT - 1));

    // Trip takes precedence over a simultaneous clear.
    always_comb begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      if (!stall[PIPE_PC] || trip) wd_cnt_d = '0;
      wd_err_d = wd_err_q;
      if (trip)        wd_err_d = 1'b1;
      else if (wd_clr) wd_err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wd_cnt_q <= '0;
        wd_err_q <= 1'b0;
      end else begin
        wd_cnt_q <= wd_cnt_d;
        wd_err_q <= wd_err_d;
      end
    end

    assign wd_trip = trip;
    assign wd_err  = wd_err_q;
  end else begin : g_no_wd
    assign wd_trip = 1'b0;
    assign wd_err  = 1'b0;
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;
  logic        raw_flush0_q, raw_flush0_d;

  always_comb begin
    raw_flush0_d     = raw_flush[PIPE_PC];
    perf_stall_cnt_d = perf_stall_cnt_q;
    perf_flush_cnt_d = perf_flush_cnt_q;
    if (stall[PIPE_PC] && (perf_stall_cnt_q != '1))
      perf_stall_cnt_d = perf_stall_cnt_q + 1'b1;
    if (raw_flush[PIPE_PC] && !raw_flush0_q && (perf_flush_cnt_q != '1))
      perf_flush_cnt_d = perf_flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt_q <= '0;
      perf_flush_cnt_q <= '0;
      raw_flush0_q     <= 1'b0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
      raw_flush0_q     <= raw_flush0_d;
    end
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench: two controllers (stretched/masked/watchdog and legacy-equivalent)
// share stimulus; directed vectors push expectations, a negedge monitor checks them.
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  stall_req;
  logic [15:0] flush_req;
  logic        wd_clr;

  logic [3:0]  stall_a, flush_a, stall_b, flush_b;
  logic        trip_a, err_a, trip_b, err_b;
  logic [31:0] psc_a, pfc_a, psc_b, pfc_b;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.NSTAGE(4), .FLUSH_HOLD(3), .FLUSH_OVER_STALL(1), .WD_LIMIT(8)) u_a (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .flush_req(flush_req),
    .wd_clr(wd_clr), .stall(stall_a), .flush(flush_a), .wd_trip(trip_a),
    .wd_err(err_a), .perf_stall_cnt(psc_a), .perf_flush_cnt(pfc_a)
  );

  pipe_ctrl_unit #(.NSTAGE(4), .FLUSH_HOLD(1), .FLUSH_OVER_STALL(0), .WD_LIMIT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .flush_req(flush_req),
    .wd_clr(wd_clr), .stall(stall_b), .flush(flush_b), .wd_trip(trip_b),
    .wd_err(err_b), .perf_stall_cnt(psc_b), .perf_flush_cnt(pfc_b)
  );

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [31:0] PS = 32'd5;
  localparam logic [31:0] PF = 32'd2;
`else
  localparam logic [31:0] PS = 32'd0;
  localparam logic [31:0] PF = 32'd0;
`endif

  typedef struct {
    int          idx;
    logic [3:0]  sa, fa, sb, fb;
    logic        ta, ea, cp;
    logic [31:0] ps, pf;
  } exp_t;

  exp_t q[$];
  int   n_run  = 0;
  int   n_fail = 0;
  int   step_no = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d got %0h expected %0h", nm, idx, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall_a", e.idx, 32'(stall_a), 32'(e.sa));
      chk("flush_a", e.idx, 32'(flush_a), 32'(e.fa));
      chk("trip_a",  e.idx, 32'(trip_a),  32'(e.ta));
      chk("err_a",   e.idx, 32'(err_a),   32'(e.ea));
      chk("stall_b", e.idx, 32'(stall_b), 32'(e.sb));
      chk("flush_b", e.idx, 32'(flush_b), 32'(e.fb));
      chk("trip_b",  e.idx, 32'(trip_b),  32'd0);
      chk("err_b",   e.idx, 32'(err_b),   32'd0);
      if (e.cp) begin
        chk("perf_stall_a", e.idx, psc_a, e.ps);
        chk("perf_flush_a", e.idx, pfc_a, e.pf);
        chk("perf_stall_b", e.idx, psc_b, e.ps);
        chk("perf_flush_b", e.idx, pfc_b, e.pf);
      end
    end
  end

  task automatic v(input logic rst, input logic [3:0] sr, input logic [15:0] fr, input logic clr,
                   input logic [3:0] sa, input logic [3:0] fa, input logic ta, input logic ea,
                   input logic [3:0] sb, input logic [3:0] fb,
                   input logic cp = 1'b0, input logic [31:0] ps = 0, input logic [31:0] pf = 0);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; stall_req = sr; flush_req = fr; wd_clr = clr;
    e.idx = step_no; e.sa = sa; e.fa = fa; e.ta = ta; e.ea = ea;
    e.sb = sb; e.fb = fb; e.cp = cp; e.ps = ps; e.pf = pf;
    q.push_back(e);
    step_no++;
  endtask

  initial begin
    rst_n = 1'b0; stall_req = '0; flush_req = '0; wd_clr = 1'b0;
    // reset state
    v(0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  1, 0, 0);
    v(1, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    // upstream stall propagation
    v(1, 4'b0100, 0, 0,  4'b0111, 0, 0, 0,  4'b0111, 0);
    v(1, 4'b0001, 0, 0,  4'b0001, 0, 0, 0,  4'b0001, 0);
    v(1, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    // single flush pulse from requester 2 on boundary 1: held 3 cycles on A
    v(1, 0, 16'h0200, 0,  0, 4'b0010, 0, 0,  0, 4'b0010);
    v(1, 0, 0, 0,  0, 4'b0010, 0, 0,  0, 0);
    v(1, 0, 0, 0,  0, 4'b0010, 0, 0,  0, 0);
    v(1, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    // second pulse at t+1 extends hold through t+3
    v(1, 0, 16'h0200, 0,  0, 4'b0010, 0, 0,  0, 4'b0010);
    v(1, 0, 16'h0200, 0,  0, 4'b0010, 0, 0,  0, 4'b0010);
    v(1, 0, 0, 0,  0, 4'b0010, 0, 0,  0, 0);
    v(1, 0, 0, 0,  0, 4'b0010, 0, 0,  0, 0);
    v(1, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    // flush over stall: requester 3 stalls and flushes boundaries 0,1
    v(1, 4'b1000, 16'h3000, 0,  4'b1100, 4'b0011, 0, 0,  4'b1111, 4'b0011);
    v(1, 4'b1000, 0, 0,  4'b1100, 4'b0011, 0, 0,  4'b1111, 0);
    v(1, 0, 0, 0,  0, 4'b0011, 0, 0,  0, 0);
    v(1, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    // watchdog: trip in 8th consecutive stall cycle
    for (int i = 0; i < 7; i++) v(1, 4'b0001, 0, 0,  4'b0001, 0, 0, 0,  4'b0001, 0);
    v(1, 4'b0001, 0, 0,  4'b0001, 0, 1, 0,  4'b0001, 0);
    for (int i = 0; i < 7; i++) v(1, 4'b0001, 0, 0,  4'b0001, 0, 0, 1,  4'b0001, 0);
    v(1, 4'b0001, 0, 1,  4'b0001, 0, 1, 1,  4'b0001, 0);
    v(1, 0, 0, 1,  0, 0, 0, 1,  0, 0);
    v(1, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    // reset while hold is active
    v(1, 0, 16'h0200, 0,  0, 4'b0010, 0, 0,  0, 4'b0010);
    v(0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  1, 0, 0);
    v(1, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    v(1, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    // perf: 5 stall cycles and two separate boundary-0 flush pulses
    for (int i = 0; i < 5; i++) v(1, 4'b0001, 0, 0,  4'b0001, 0, 0, 0,  4'b0001, 0);
    v(1, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    for (int k = 0; k < 2; k++) begin
      v(1, 0, 16'h0001, 0,  0, 4'b0001, 0, 0,  0, 4'b0001);
      v(1, 0, 0, 0,  0, 4'b0001, 0, 0,  0, 0);
      v(1, 0, 0, 0,  0, 4'b0001, 0, 0,  0, 0);
      v(1, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    end
    v(1, 0, 0, 0,  0, 0, 0, 0,  0, 0,  1, PS, PF);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
